// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Provides the access-size encoding, the controller state encoding, the
// lane count of a memory word and a helper that classifies misaligned accesses.
package dmem_pkg;

  localparam int unsigned NumLanes = 4;
  localparam int unsigned LaneW    = 8;

  typedef enum logic [1:0] {
    SzByte    = 2'b00,
    SzHalf    = 2'b01,
    SzWord    = 2'b10,
    SzIllegal = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StClear = 2'b00,
    StLoad  = 2'b01,
    StRun   = 2'b10
  } state_e;

  // Illegal size, odd half address and non-word-aligned word address all fault.
  function automatic logic is_misaligned(size_e sz, logic [1:0] off);
    logic bad;
    unique case (sz)
      SzByte:  bad = 1'b0;
      SzHalf:  bad = off[0];
      SzWord:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Bus bundle between a CPU/loader and dmem_ctrl.
// CPU side: mem_read, mem_write, address, size, sign_ext, write_data -> read_data,
//   rd_valid, misalign.
// Loader side: upg_valid, upg_adr, upg_dat, upg_done, upg_start -> upg_ready.
// Status: busy (not in RUN), state (current controller state).
interface dmem_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W+1:0] address;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              rd_valid;
  logic              misalign;

  logic              upg_valid;
  logic              upg_ready;
  logic [ADDR_W-1:0] upg_adr;
  logic [31:0]       upg_dat;
  logic              upg_done;
  logic              upg_start;

  logic              busy;
  logic [1:0]        state;

  modport master (
    output mem_read, mem_write, address, size, sign_ext, write_data,
    input  read_data, rd_valid, misalign,
    output upg_valid, upg_adr, upg_dat, upg_done, upg_start,
    input  upg_ready, busy, state
  );

  modport slave (
    input  mem_read, mem_write, address, size, sign_ext, write_data,
    output read_data, rd_valid, misalign,
    input  upg_valid, upg_adr, upg_dat, upg_done, upg_start,
    output upg_ready, busy, state
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering for the data memory (purely combinational).
// Request side: req_size_i/req_off_i/wr_data_i -> wr_be_o (byte enables),
//   wr_data_o (data replicated onto every candidate lane), fault_o.
// Response side: rd_word_i with the captured rd_size_i/rd_off_i/rd_sign_i ->
//   rd_data_o (extracted and zero/sign-extended result).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e                req_size_i,
  input  logic [1:0]           req_off_i,
  input  logic [31:0]          wr_data_i,
  output logic [NumLanes-1:0]  wr_be_o,
  output logic [31:0]          wr_data_o,
  output logic                 fault_o,

  input  logic [31:0]          rd_word_i,
  input  size_e                rd_size_i,
  input  logic [1:0]           rd_off_i,
  input  logic                 rd_sign_i,
  output logic [31:0]          rd_data_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign fault_o = is_misaligned(req_size_i, req_off_i);

  // Replicating the sub-word onto all lanes lets the byte enables alone pick
  // the destination lane.
  always_comb begin
    wr_be_o   = '0;
    wr_data_o = '0;
    unique case (req_size_i)
      SzByte: begin
        wr_be_o   = 4'b0001 << req_off_i;
        wr_data_o = {4{wr_data_i[7:0]}};
      end
      SzHalf: begin
        wr_be_o   = req_off_i[1] ? 4'b1100 : 4'b0011;
        wr_data_o = {2{wr_data_i[15:0]}};
      end
      SzWord: begin
        wr_be_o   = 4'b1111;
        wr_data_o = wr_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte   = rd_word_i[{rd_off_i, 3'b000} +: 8];
    rd_half   = rd_word_i[{rd_off_i[1], 4'b0000} +: 16];
    rd_data_o = rd_word_i;
    unique case (rd_size_i)
      SzByte:  rd_data_o = {{24{rd_sign_i & rd_byte[7]}}, rd_byte};
      SzHalf:  rd_data_o = {{16{rd_sign_i & rd_half[15]}}, rd_half};
      default: rd_data_o = rd_word_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: 2**ADDR_W x 32-bit memory with a post-reset
// zero-fill sweep (CLEAR), a loader phase (LOAD) and CPU byte/half/word access (RUN).
// Ports: clock, reset (synchronous, active-high), bus (dmem_if.slave) carrying the
// CPU request/response, loader handshake and busy/state status.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter bit          CLEAR_EN = 1'b1,
  parameter bit          LOAD_EN  = 1'b1
) (
  input logic   clock,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam state_e ResetState = CLEAR_EN ? StClear : (LOAD_EN ? StLoad : StRun);
  localparam state_e PostClear  = LOAD_EN ? StLoad : StRun;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic [31:0] mem_q [Depth];

  // CPU request decode
  size_e             req_size;
  logic [1:0]        req_off;
  logic [ADDR_W-1:0] cpu_idx;
  logic              in_run;
  logic              fault;
  logic              rd_en;
  logic              cpu_wr;
  logic [NumLanes-1:0] cpu_be;
  logic [31:0]         cpu_wdata;

  // Memory write port
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_widx;
  logic [NumLanes-1:0] mem_be;
  logic [31:0]         mem_wdata;

  // Read pipeline
  logic [31:0] rd_word_q;
  size_e       rd_size_q;
  logic [1:0]  rd_off_q;
  logic        rd_sign_q;
  logic        rd_valid_q;
  logic        misalign_q;
  logic [31:0] rd_data;

  assign req_size = size_e'(bus.size);
  assign req_off  = bus.address[1:0];
  assign cpu_idx  = bus.address[ADDR_W+1:2];
  assign in_run   = (state_q == StRun);

  // A simultaneous read+write is treated as a write only.
  assign rd_en  = in_run & bus.mem_read & ~bus.mem_write & ~fault;
  assign cpu_wr = in_run & bus.mem_write & ~fault;

  dmem_lane_align u_lane_align (
    .req_size_i (req_size),
    .req_off_i  (req_off),
    .wr_data_i  (bus.write_data),
    .wr_be_o    (cpu_be),
    .wr_data_o  (cpu_wdata),
    .fault_o    (fault),
    .rd_word_i  (rd_word_q),
    .rd_size_i  (rd_size_q),
    .rd_off_i   (rd_off_q),
    .rd_sign_i  (rd_sign_q),
    .rd_data_o  (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        // Leave after the last word rather than wrapping the sweep.
        if (clr_cnt_q == ADDR_W'(Depth - 1)) begin
          state_d   = PostClear;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      StLoad: begin
        if (bus.upg_done) state_d = StRun;
      end
      StRun: begin
        if (LOAD_EN && bus.upg_start) state_d = StLoad;
      end
      default: state_d = ResetState;
    endcase
  end

  // Single write port shared by the sweep, the loader and the CPU.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = cpu_idx;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (state_q)
      StClear: begin
        mem_we   = 1'b1;
        mem_widx = clr_cnt_q;
        mem_be   = '1;
      end
      StLoad: begin
        mem_we    = bus.upg_valid;
        mem_widx  = bus.upg_adr;
        mem_be    = '1;
        mem_wdata = bus.upg_dat;
      end
      StRun: begin
        mem_we    = cpu_wr;
        mem_be    = cpu_be;
        mem_wdata = cpu_wdata;
      end
      default: ;
    endcase
    // Reset aborts whatever phase is active without touching memory.
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (mem_be[i]) mem_q[mem_widx][i*LaneW +: LaneW] <= mem_wdata[i*LaneW +: LaneW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ResetState;
      clr_cnt_q  <= '0;
      rd_word_q  <= '0;
      rd_size_q  <= SzByte;
      rd_off_q   <= '0;
      rd_sign_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_valid_q <= rd_en;
      misalign_q <= in_run & (bus.mem_read | bus.mem_write) & fault;
      // Capture the lane info with the word so read_data holds until the next read.
      if (rd_en) begin
        rd_word_q <= mem_q[cpu_idx];
        rd_size_q <= req_size;
        rd_off_q  <= req_off;
        rd_sign_q <= bus.sign_ext;
      end
    end
  end

  assign bus.read_data = rd_data;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.misalign  = misalign_q;
  assign bus.upg_ready = (state_q == StLoad);
  assign bus.busy      = (state_q != StRun);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with ADDR_W=4 (16 words).
module tb_dmem_ctrl;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  dmem_if #(.ADDR_W(4)) bus ();

  dmem_ctrl #(
    .ADDR_W   (4),
    .CLEAR_EN (1'b1),
    .LOAD_EN  (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.address    = '0;
    bus.size       = 2'b10;
    bus.sign_ext   = 1'b0;
    bus.write_data = '0;
    bus.upg_valid  = 1'b0;
    bus.upg_adr    = '0;
    bus.upg_dat    = '0;
    bus.upg_done   = 1'b0;
    bus.upg_start  = 1'b0;
  endtask

  // Presents one CPU request for one cycle; outputs are sampled after return.
  task automatic cpu_access(input logic rd, input logic wr, input logic [5:0] addr,
                            input logic [1:0] sz, input logic sext, input logic [31:0] wdata);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.address    = addr;
    bus.size       = sz;
    bus.sign_ext   = sext;
    bus.write_data = wdata;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    n_cmp++;
    if (bus.state !== 2'b00) begin
      n_err++; $display("FAIL reset_state: got %b want 00", bus.state);
    end
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL reset_busy: got %b want 1", bus.busy);
    end
    n_cmp++;
    if ({bus.rd_valid, bus.misalign, bus.upg_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 000", {bus.rd_valid, bus.misalign, bus.upg_ready});
    end
    n_cmp++;
    if (bus.read_data !== 32'h0) begin
      n_err++; $display("FAIL reset_read_data: got %h want 00000000", bus.read_data);
    end
  endtask

  // Releases reset and checks 16 CLEAR cycles followed by LOAD at cycle 16.
  task automatic test_clear_sweep(input string tag);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (bus.state !== 2'b00 || bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s_cycle%0d: got state=%b busy=%b want state=00 busy=1",
                 tag, k, bus.state, bus.busy);
      end
      step();
    end
    n_cmp++;
    if (bus.state !== 2'b01 || bus.upg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_to_load: got state=%b upg_ready=%b want state=01 upg_ready=1",
               tag, bus.state, bus.upg_ready);
    end
  endtask

  task automatic test_load();
    bus.upg_valid = 1'b1;
    bus.upg_adr   = 4'd3;
    bus.upg_dat   = 32'hDEADBEEF;
    bus.upg_done  = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (bus.state !== 2'b10 || bus.busy !== 1'b0 || bus.upg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL load_to_run: got state=%b busy=%b ready=%b want 10/0/0",
               bus.state, bus.busy, bus.upg_ready);
    end
    cpu_access(1'b1, 1'b0, 6'h0C, 2'b10, 1'b0, 32'h0);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.read_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL load_readback: got v=%b d=%h want v=1 d=deadbeef",
               bus.rd_valid, bus.read_data);
    end
    step();
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.read_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL read_hold: got v=%b d=%h want v=0 d=deadbeef", bus.rd_valid, bus.read_data);
    end
  endtask

  // Word-reads all 16 words; word `special` must hold `sval`, all others zero.
  task automatic test_read_all(input string tag, input int special, input logic [31:0] sval);
    logic [31:0] exp;
    for (int w = 0; w < 16; w++) begin
      exp = (w == special) ? sval : 32'h0;
      cpu_access(1'b1, 1'b0, 6'(w * 4), 2'b10, 1'b0, 32'h0);
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.read_data !== exp) begin
        n_err++;
        $display("FAIL %s_word%0d: got v=%b d=%h want v=1 d=%h",
                 tag, w, bus.rd_valid, bus.read_data, exp);
      end
    end
  endtask

  task automatic test_subword();
    // Upper bits of write_data must be ignored for a byte store.
    cpu_access(1'b0, 1'b1, 6'h0D, 2'b00, 1'b0, 32'hABCD1280);
    cpu_access(1'b1, 1'b0, 6'h0D, 2'b00, 1'b1, 32'h0);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.read_data !== 32'hFFFFFF80) begin
      n_err++;
      $display("FAIL lb_sext: got v=%b d=%h want v=1 d=ffffff80", bus.rd_valid, bus.read_data);
    end
    cpu_access(1'b1, 1'b0, 6'h0D, 2'b00, 1'b0, 32'h0);
    n_cmp++;
    if (bus.read_data !== 32'h00000080) begin
      n_err++; $display("FAIL lbu: got %h want 00000080", bus.read_data);
    end
    cpu_access(1'b1, 1'b0, 6'h0C, 2'b10, 1'b0, 32'h0);
    n_cmp++;
    if (bus.read_data !== 32'hDEAD80EF) begin
      n_err++; $display("FAIL lw_after_sb: got %h want dead80ef", bus.read_data);
    end
    // Half store into the upper lanes of word 5.
    cpu_access(1'b0, 1'b1, 6'h16, 2'b01, 1'b0, 32'hFFFF9ABC);
    cpu_access(1'b1, 1'b0, 6'h14, 2'b10, 1'b0, 32'h0);
    n_cmp++;
    if (bus.read_data !== 32'h9ABC0000) begin
      n_err++; $display("FAIL lw_after_sh: got %h want 9abc0000", bus.read_data);
    end
    cpu_access(1'b1, 1'b0, 6'h16, 2'b01, 1'b1, 32'h0);
    n_cmp++;
    if (bus.read_data !== 32'hFFFF9ABC) begin
      n_err++; $display("FAIL lh_sext: got %h want ffff9abc", bus.read_data);
    end
    cpu_access(1'b1, 1'b0, 6'h0E, 2'b01, 1'b0, 32'h0);
    n_cmp++;
    if (bus.read_data !== 32'h0000DEAD) begin
      n_err++; $display("FAIL lhu_hi: got %h want 0000dead", bus.read_data);
    end
    cpu_access(1'b1, 1'b0, 6'h0F, 2'b00, 1'b1, 32'h0);
    n_cmp++;
    if (bus.read_data !== 32'hFFFFFFDE) begin
      n_err++; $display("FAIL lb_lane3: got %h want ffffffde", bus.read_data);
    end
  endtask

  task automatic test_misalign();
    logic [5:0] addrs [4] = '{6'h01, 6'h02, 6'h0D, 6'h0C};
    logic [1:0] sizes [4] = '{2'b01, 2'b10, 2'b01, 2'b11};
    logic       wrs   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cpu_access(~wrs[i], wrs[i], addrs[i], sizes[i], 1'b0, 32'h0);
      n_cmp++;
      if (bus.misalign !== 1'b1 || bus.rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL misalign%0d: got mis=%b v=%b want mis=1 v=0", i, bus.misalign, bus.rd_valid);
      end
      step();
      n_cmp++;
      if (bus.misalign !== 1'b0) begin
        n_err++; $display("FAIL misalign%0d_pulse: got %b want 0", i, bus.misalign);
      end
    end
    cpu_access(1'b1, 1'b0, 6'h0C, 2'b10, 1'b0, 32'h0);
    n_cmp++;
    if (bus.read_data !== 32'hDEAD80EF || bus.misalign !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_mem_intact: got d=%h mis=%b want d=dead80ef mis=0",
               bus.read_data, bus.misalign);
    end
  endtask

  task automatic test_read_write_same();
    cpu_access(1'b1, 1'b1, 6'h08, 2'b10, 1'b0, 32'h55AA55AA);
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin
      n_err++; $display("FAIL rw_no_read: got v=%b want 0", bus.rd_valid);
    end
    cpu_access(1'b1, 1'b0, 6'h08, 2'b10, 1'b0, 32'h0);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.read_data !== 32'h55AA55AA) begin
      n_err++;
      $display("FAIL rw_readback: got v=%b d=%h want v=1 d=55aa55aa", bus.rd_valid, bus.read_data);
    end
  endtask

  task automatic test_reprogram();
    bus.upg_start = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (bus.state !== 2'b01 || bus.busy !== 1'b1 || bus.upg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reprog_load: got state=%b busy=%b ready=%b want 01/1/1",
               bus.state, bus.busy, bus.upg_ready);
    end
    // CPU requests are ignored while busy, including illegal ones.
    cpu_access(1'b1, 1'b0, 6'h0C, 2'b10, 1'b0, 32'h0);
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.misalign !== 1'b0) begin
      n_err++; $display("FAIL busy_read: got v=%b mis=%b want 0/0", bus.rd_valid, bus.misalign);
    end
    cpu_access(1'b1, 1'b0, 6'h01, 2'b01, 1'b0, 32'h0);
    n_cmp++;
    if (bus.misalign !== 1'b0) begin
      n_err++; $display("FAIL busy_misalign: got %b want 0", bus.misalign);
    end
    bus.upg_done = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (bus.state !== 2'b10) begin
      n_err++; $display("FAIL reprog_run: got state=%b want 10", bus.state);
    end
    cpu_access(1'b1, 1'b0, 6'h0C, 2'b10, 1'b0, 32'h0);
    n_cmp++;
    if (bus.read_data !== 32'hDEAD80EF) begin
      n_err++; $display("FAIL reprog_word3: got %h want dead80ef", bus.read_data);
    end
    cpu_access(1'b1, 1'b0, 6'h08, 2'b10, 1'b0, 32'h0);
    n_cmp++;
    if (bus.read_data !== 32'h55AA55AA) begin
      n_err++; $display("FAIL reprog_word2: got %h want 55aa55aa", bus.read_data);
    end
  endtask

  task automatic test_abort_clear();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    // Now in sweep cycle k=5: reset here must restart the sweep from word 0.
    reset = 1'b1;
    step();
    n_cmp++;
    if (bus.state !== 2'b00 || bus.read_data !== 32'h0) begin
      n_err++;
      $display("FAIL abort_reset: got state=%b d=%h want 00/0", bus.state, bus.read_data);
    end
    test_clear_sweep("restart");
    bus.upg_done = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (bus.state !== 2'b10) begin
      n_err++; $display("FAIL abort_run: got state=%b want 10", bus.state);
    end
    test_read_all("zeroed", -1, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_clear_sweep("clear");
    test_load();
    test_read_all("after_load", 3, 32'hDEADBEEF);
    test_subword();
    test_misalign();
    test_read_write_same();
    test_reprogram();
    test_abort_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width; DEPTH = 2**ADDR_W words of 32 bits.
REQ-002 SHALL have parameter CLEAR_EN, default 1, zero-fill sweep after reset when 1.
REQ-003 SHALL have parameter LOAD_EN, default 1, UART-load phase enabled when 1.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-005 SHALL have: mem_read  in  1  CPU read request; mem_write  in  1  CPU write request; address  in  ADDR_W+2  byte address.
REQ-006 SHALL have: size  in  2  00 byte / 01 half / 10 word / 11 illegal; sign_ext  in  1  sign-extend sub-word reads.
REQ-007 SHALL have: write_data  in  32  store data, low-aligned; read_data  out  32  load result; rd_valid  out  1  load-result strobe; misalign  out  1  access-fault strobe.
REQ-008 SHALL have: upg_valid  in  1; upg_ready  out  1; upg_adr  in  ADDR_W; upg_dat  in  32; upg_done  in  1  load finished; upg_start  in  1  reprogram request.
REQ-009 SHALL have: busy  out  1  not in RUN; state  out  2  current FSM state.

Function
REQ-010 SHALL implement the FSM CLEAR(00) -> LOAD(01) -> RUN(10); CLEAR is skipped when CLEAR_EN=0, and LOAD is skipped when LOAD_EN=0.
REQ-011 SHALL, in CLEAR, write 0 to word k in cycle k (k = 0..DEPTH-1) and leave CLEAR after exactly DEPTH cycles, with no wrap.
REQ-012 SHALL, in LOAD, hold upg_ready=1; on upg_valid&upg_ready it SHALL write upg_dat to word upg_adr at that edge.
REQ-013 SHALL, when upg_done=1 is sampled in LOAD, enter RUN next cycle; if upg_valid is high in the same cycle, that word SHALL still be written.
REQ-014 SHALL, on upg_start=1 in RUN with LOAD_EN=1, enter LOAD next cycle without clearing memory; upg_start SHALL be ignored in other states.
REQ-015 SHALL ignore CPU requests while busy=1, with rd_valid=0 and misalign=0.
REQ-016 SHALL, in RUN, deliver read_data and rd_valid=1 in cycle N+1 for a read in cycle N; read_data SHALL hold until the next valid read.
REQ-017 SHALL, in RUN, commit a write at the edge ending its request cycle; a read of the same address in the next cycle SHALL return the new data.
REQ-018 SHALL perform the write only when mem_read and mem_write are both 1: no read, rd_valid=0.
REQ-019 SHALL use little-endian lanes: byte lane = address[1:0], lane 0 = bits 7:0; half uses lane address[1]*2.
REQ-020 SHALL modify only the addressed lanes on sub-word writes, using write_data[7:0] or [15:0].
REQ-021 SHALL zero- or sign-extend sub-word reads per sign_ext.
REQ-022 SHALL treat half with address[0]=1, word with address[1:0]!=0, and size=11 as faults: no memory access, misalign=1 for one cycle in N+1, rd_valid=0.
REQ-023 SHALL index words by address[ADDR_W+1:2].

Reset
REQ-024 SHALL, on reset, set: state=CLEAR (or LOAD/RUN per parameters), clear counter=0, read_data=0, rd_valid=0, misalign=0, upg_ready=0, busy=1 (0 if RUN).
REQ-025 SHALL abort the current phase on reset mid-CLEAR, mid-LOAD or in RUN; memory contents SHALL not be altered except by the new sweep.

Structure
REQ-026 SHALL take size encodings, state encodings and the lane-count constant from package dmem_pkg.
REQ-027 SHALL place lane extraction, extension and write-merge in sub-module dmem_lane_align; the memory array SHALL be inferred inline with synchronous read.

Verification
REQ-028 SHALL verify, with ADDR_W=4 and CLEAR_EN=1, reset -> busy=1 for 16 CLEAR cycles, state=01 at cycle 16, and every word reads 0 afterward.
REQ-029 SHALL verify LOAD of word 3=0xDEADBEEF with upg_done in the same cycle -> state=10 next cycle, and a word read at byte 0xC returns 0xDEADBEEF with rd_valid one cycle later.
REQ-030 SHALL verify sb 0x80 to byte 0xD, then lb sign_ext=1 -> 0xFFFFFF80, lbu -> 0x00000080, and lw 0xC -> 0xDEAD80EF.
REQ-031 SHALL verify lh at 0x1 and lw at 0x2 -> misalign=1 for one cycle, rd_valid=0, memory unchanged.
REQ-032 SHALL verify simultaneous read and write of 0x55AA55AA to 0x8 -> rd_valid=0, and a next-cycle read returns 0x55AA55AA.
REQ-033 SHALL verify upg_start in RUN -> state=01 and old data intact; reset asserted mid-CLEAR at k=5 -> sweep restarts at k=0.
